// File: rtl/spi_master_transmit_only.sv
// spi_master_transmit_only
//
// SPI master that shifts one 32-bit position frame {xpos, ypos} out MSB first
// on sck/sdo, framed by an active-low cs_b. sck idles low, sdo changes on the
// clk edge that raises sck, and the slave samples on the falling sck edge.
// Each sck half-period is CLK_DIV clk cycles (legal range 1..255).
//
// Frame sequence: IDLE -> LEAD (one low half-period) -> SHIFT (32 bits)
//                 -> [TRAIL (one dummy pulse, sdo=0)] -> TAIL (one low
//                 half-period) -> IDLE with a one-cycle done pulse.
//
// Optional feature macro: SPI_TX_TRAIL_PULSE_EN
//   defined   : TRAIL state present, 33 sck pulses, latency 67*CLK_DIV
//   undefined : no TRAIL state, 32 sck pulses, latency 65*CLK_DIV
//
// Ports:
//   clk_i    in   system clock, rising edge
//   reset_i  in   asynchronous active-high reset
//   start_i  in   frame request, accepted only while ready_o=1
//   xpos_i   in   [15:0] frame bits 31:16, sampled on the accept edge
//   ypos_i   in   [15:0] frame bits 15:0, sampled on the accept edge
//   ready_o  out  high in IDLE
//   done_o   out  one-cycle pulse when a frame completes
//   sck_o    out  SPI clock
//   sdo_o    out  serial data
//   cs_b_o   out  active-low frame enable
//
// All outputs come straight from registers.

module spi_master_transmit_only #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] xpos_i,
  input  logic [15:0] ypos_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        sck_o,
  output logic        sdo_o,
  output logic        cs_b_o
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
`ifdef SPI_TX_TRAIL_PULSE_EN
    TRAIL,
`endif
    TAIL
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  halfCnt_q, halfCnt_d;
  logic [5:0]  bitCnt_q, bitCnt_d;
  logic [31:0] shiftReg_q, shiftReg_d;
  logic        sck_q, sck_d;
  logic        sdo_q, sdo_d;
  logic        csB_q, csB_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;

  logic        halfEnd;

  // The last clk cycle of the current sck half-period.
  assign halfEnd = (halfCnt_q == CNT_LAST);

  // State and output registers; reset drops any frame in progress.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      halfCnt_q  <= '0;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      csB_q      <= 1'b1;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      halfCnt_q  <= halfCnt_d;
      bitCnt_q   <= bitCnt_d;
      shiftReg_q <= shiftReg_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      csB_q      <= csB_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic. Every phase change happens on the edge that ends a
  // half-period; the half-period counter free-runs outside IDLE and wraps
  // there, so it is back at zero whenever the FSM returns to IDLE.
  always_comb begin
    state_d    = state_q;
    halfCnt_d  = halfCnt_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    csB_d      = csB_q;
    done_d     = 1'b0;
    ready_d    = ready_q;

    if (state_q != IDLE) begin
      halfCnt_d = halfEnd ? 8'd0 : halfCnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        halfCnt_d = '0;
        if (start_i) begin
          shiftReg_d = {xpos_i, ypos_i};
          bitCnt_d   = '0;
          csB_d      = 1'b0;
          ready_d    = 1'b0;
          state_d    = LEAD;
        end
      end

      LEAD: begin
        // First rising sck carries bit 31.
        if (halfEnd) begin
          sck_d      = 1'b1;
          sdo_d      = shiftReg_q[31];
          shiftReg_d = {shiftReg_q[30:0], 1'b0};
          bitCnt_d   = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (halfEnd) begin
          if (sck_q) begin
            // Falling edge: the slave samples here. After bit 0 the
            // frame body is complete.
            sck_d = 1'b0;
            if (bitCnt_q == 6'd31) begin
`ifdef SPI_TX_TRAIL_PULSE_EN
              state_d = TRAIL;
`else
              state_d = TAIL;
`endif
            end
          end else begin
            sck_d      = 1'b1;
            sdo_d      = shiftReg_q[31];
            shiftReg_d = {shiftReg_q[30:0], 1'b0};
            bitCnt_d   = bitCnt_q + 6'd1;
          end
        end
      end

`ifdef SPI_TX_TRAIL_PULSE_EN
      TRAIL: begin
        // Extra pulse so the slave's parallel register picks up the word
        // one falling edge after its shift register became full.
        if (halfEnd) begin
          if (!sck_q) begin
            sck_d = 1'b1;
            sdo_d = 1'b0;
          end else begin
            sck_d   = 1'b0;
            state_d = TAIL;
          end
        end
      end
`endif

      TAIL: begin
        // Frame ends: ready rises together with done so a held start is
        // accepted on the very next edge.
        if (halfEnd) begin
          csB_d   = 1'b1;
          sdo_d   = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        halfCnt_d = '0;
        sck_d     = 1'b0;
        sdo_d     = 1'b0;
        csB_d     = 1'b1;
        ready_d   = 1'b1;
      end
    endcase
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign sck_o   = sck_q;
  assign sdo_o   = sdo_q;
  assign cs_b_o  = csB_q;

endmodule

// File: tb/tb_spi_master_transmit_only.sv
// Testbench for spi_master_transmit_only.
//
// Two instances share the clock, reset and frame data: one with CLK_DIV=2
// and one with CLK_DIV=1; 'sel' picks which one receives start and is
// observed. The expected waveform of a frame is computed directly from the
// edge-timing formulas (bit n rises at T*(1+2n), falls at T*(2+2n), done at
// 65T or 67T), and a sampling model captures sdo on each falling sck.

module tb_spi_master_transmit_only;

`ifdef SPI_TX_TRAIL_PULSE_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        startDrv;
  logic        sel;
  logic [15:0] xpos;
  logic [15:0] ypos;

  logic start2, ready2, done2, sck2, sdo2, csB2;
  logic start1, ready1, done1, sck1, sdo1, csB1;
  logic [4:0] obs;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] slvShift;
  logic [31:0] slvOut;
  int          slvCnt;

  assign start2 = startDrv & ~sel;
  assign start1 = startDrv & sel;
  // Observed vector layout: {sck, sdo, cs_b, done, ready}
  assign obs = sel ? {sck1, sdo1, csB1, done1, ready1}
                   : {sck2, sdo2, csB2, done2, ready2};

  spi_master_transmit_only #(.CLK_DIV(2)) dut2 (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start2),
    .xpos_i  (xpos),
    .ypos_i  (ypos),
    .ready_o (ready2),
    .done_o  (done2),
    .sck_o   (sck2),
    .sdo_o   (sdo2),
    .cs_b_o  (csB2)
  );

  spi_master_transmit_only #(.CLK_DIV(1)) dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start1),
    .xpos_i  (xpos),
    .ypos_i  (ypos),
    .ready_o (ready1),
    .done_o  (done1),
    .sck_o   (sck1),
    .sdo_o   (sdo1),
    .cs_b_o  (csB1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts the test and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {sck, sdo, cs_b, done, ready} k cycles after the accept edge.
  function automatic logic [4:0] expTrace(input logic [31:0] w, input int k,
                                          input int t);
    int   lat;
    int   pulses;
    int   p;
    logic s;
    logic d;
    lat    = (TRAIL ? 67 : 65) * t;
    pulses = TRAIL ? 33 : 32;
    if (k > lat)  return 5'b00101;
    if (k == lat) return 5'b00111;
    s = 1'b0;
    d = 1'b0;
    if (k >= t) begin
      p = (k - t) / (2 * t);
      s = (p < pulses) && (((k - t) % (2 * t)) < t);
      d = (p < 32) ? w[31 - p] : 1'b0;
    end
    return {s, d, 3'b000};
  endfunction

  // Sends w0 (and w1 back-to-back when b2b=1) on the selected instance and
  // checks every cycle. noise=1 drives random start/data while busy,
  // noise=2 pokes start with DEADBEEF at accept+10.
  task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1,
                               input bit b2b, input int noise);
    int          t;
    int          lat;
    int          pulses;
    int          endK;
    int          firstDone;
    int          falls;
    int          nBits;
    logic [31:0] word;
    logic        prevSck;
    logic        prevCs;
    logic [31:0] capW[$];
    int          capN[$];

    t      = sel ? 1 : 2;
    lat    = (TRAIL ? 67 : 65) * t;
    pulses = TRAIL ? 33 : 32;
    endK   = b2b ? 2 * lat + 4 : lat + 3;

    @(negedge clk);
    checkOutput("idleBefore", 32'(obs), 32'b00101);
    prevSck   = obs[4];
    prevCs    = obs[2];
    startDrv  = 1'b1;
    {xpos, ypos} = w0;
    firstDone = -1;
    falls     = 0;
    nBits     = 0;
    word      = '0;

    for (int k = 0; k <= endK; k++) begin
      @(negedge clk);
      if (b2b && k > lat) checkOutput("trace", 32'(obs), 32'(expTrace(w1, k - lat - 1, t)));
      else                checkOutput("trace", 32'(obs), 32'(expTrace(w0, k, t)));
      if (obs[1] && firstDone < 0) firstDone = k;
      if (prevCs && !obs[2]) slvCnt = 0;
      if (prevSck && !obs[4] && !obs[2]) begin
        falls++;
        if (nBits < 32) word = {word[30:0], obs[3]};
        nBits++;
        if (slvCnt == 32) slvOut = slvShift;
        slvShift = {slvShift[30:0], obs[3]};
        slvCnt++;
      end
      if (!prevCs && obs[2]) begin
        capW.push_back(word);
        capN.push_back(nBits);
        word  = '0;
        nBits = 0;
      end
      prevSck = obs[4];
      prevCs  = obs[2];

      if (b2b) begin
        startDrv     = (k <= lat);
        {xpos, ypos} = w1;
      end else if (noise == 1) begin
        startDrv     = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
        {xpos, ypos} = $urandom();
      end else if (noise == 2) begin
        startDrv     = (k == 9);
        {xpos, ypos} = (k == 9) ? 32'hDEADBEEF : w0;
      end else begin
        startDrv = 1'b0;
      end
    end
    startDrv = 1'b0;

    checkOutput("doneAt", 32'(firstDone), 32'(lat));
    checkOutput("fallCount", 32'(falls), 32'((b2b ? 2 : 1) * pulses));
    checkOutput("frameCount", 32'(capW.size()), b2b ? 32'd2 : 32'd1);
    for (int i = 0; i < capW.size(); i++) begin
      checkOutput("capturedWord", capW[i], (i == 0) ? w0 : w1);
      checkOutput("bitsPerFrame", 32'(capN[i]), 32'(pulses));
    end
  endtask

  initial begin
    logic [31:0] rw;
    bit          rb;

    reset    = 1'b1;
    startDrv = 1'b0;
    sel      = 1'b0;
    xpos     = '0;
    ypos     = '0;
    slvShift = '0;
    slvOut   = '0;
    slvCnt   = 0;

    repeat (3) @(negedge clk);
    checkOutput("resetDiv2", 32'(obs), 32'b00101);
    sel = 1'b1;
    #1 checkOutput("resetDiv1", 32'(obs), 32'b00101);
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single frame 1234ABCD");
    applyStimulus(32'h1234ABCD, 32'h0, 1'b0, 0);

    $display("[TB] back-to-back frames");
    applyStimulus(32'hFFFF0000, 32'h0000FFFF, 1'b1, 0);

    $display("[TB] busy rejection");
    applyStimulus(32'h00000001, 32'h0, 1'b0, 2);

    $display("[TB] reset mid-frame");
    rw = $urandom();
    @(negedge clk);
    startDrv     = 1'b1;
    {xpos, ypos} = rw;
    @(negedge clk);
    startDrv = 1'b0;
    repeat (19) @(negedge clk);
    checkOutput("preReset", 32'(obs), 32'(expTrace(rw, 19, 2)));
    reset = 1'b1;
    #1 checkOutput("asyncReset", 32'(obs), 32'b00101);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(32'hA5A5A5A5, 32'h0, 1'b0, 0);

    $display("[TB] slave parallel output");
    slvOut = '0;
    applyStimulus(32'h014000F0, 32'h0, 1'b0, 0);
    checkOutput("slaveOut", slvOut, TRAIL ? 32'h014000F0 : 32'h0);

    $display("[TB] random frames, CLK_DIV=2");
    for (int i = 0; i < 4; i++) begin
      rb = 1'($urandom_range(0, 1));
      applyStimulus($urandom(), $urandom(), rb, rb ? 0 : 1);
    end

    $display("[TB] CLK_DIV=1");
    @(negedge clk);
    sel = 1'b1;
    applyStimulus(32'h80000001, 32'h0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      rb = 1'($urandom_range(0, 1));
      applyStimulus($urandom(), $urandom(), rb, rb ? 0 : 1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
